// File: rtl/rd_skew_control_pkg.sv
// rd_skew_control shared package
// Defaults, FSM encoding, lane helpers
package rd_skew_control_pkg;

  localparam int WH_DEF = 4;
  localparam int LANE_W = 8;
  localparam int ADDR_W_DEF = LANE_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // drain counter must hold W-1
  function automatic int drain_w(int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/rd_skew_stage.sv
// One lane of the read skew delay chain
// Ports: clk, reset(n), en_in/addr_in -> en/addr
module rd_skew_stage
  import rd_skew_control_pkg::*;
#(
  parameter int ADDR_W = LANE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en_in,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              en,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en   <= 1'b0;
      addr <= '0;
    end else begin
      en   <= en_in;
      addr <= en_in ? addr_in : '0;
    end
  end

endmodule

// File: rtl/rd_skew_control.sv
// Skewed read enable/address sequencer
// Ports: clk, reset(n), start, base_addr, num_rows -> busy, done, rd_en, rd_addr
module rd_skew_control
  import rd_skew_control_pkg::*;
#(
  parameter int WIDTH_HEIGHT = WH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ADDR_W-1:0]              num_rows,
  output logic                           busy,
  output logic                           done,
  output logic [WIDTH_HEIGHT-1:0]        rd_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr
);

  localparam int DW = drain_w(WIDTH_HEIGHT);

  logic [1:0]        state;
  logic [ADDR_W-1:0] rem;
  logic [ADDR_W-1:0] addr0;
  logic              en0;
  logic [DW-1:0]     drain;

  logic [WIDTH_HEIGHT-1:0] en_c;
  logic [ADDR_W-1:0]       addr_c [WIDTH_HEIGHT];

  // rem = reads still to issue after the current one
  // drain ticks once per edge after lane 0 is spent
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      en0   <= 1'b0;
      addr0 <= '0;
      rem   <= '0;
      drain <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            drain <= DW'(WIDTH_HEIGHT - 1);
            if (num_rows != '0) begin
              state <= ST_RUN;
              en0   <= 1'b1;
              addr0 <= base_addr;
              rem   <= num_rows - ADDR_W'(1);
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (rem != '0) begin
            en0   <= 1'b1;
            addr0 <= addr0 + ADDR_W'(1);
            rem   <= rem - ADDR_W'(1);
          end else begin
            en0   <= 1'b0;
            addr0 <= '0;
            if (drain == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              drain <= drain - DW'(1);
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          en0   <= 1'b0;
          addr0 <= '0;
        end
      endcase
    end
  end

  assign en_c[0]   = en0;
  assign addr_c[0] = addr0;

  for (genvar i = 1; i < WIDTH_HEIGHT; i++) begin : g_lane
    rd_skew_stage #(
      .ADDR_W(ADDR_W)
    ) u_stage (
      .clk    (clk),
      .reset  (reset),
      .en_in  (en_c[i-1]),
      .addr_in(addr_c[i-1]),
      .en     (en_c[i]),
      .addr   (addr_c[i])
    );
  end

  for (genvar i = 0; i < WIDTH_HEIGHT; i++) begin : g_pack
    assign rd_addr[i*ADDR_W +: ADDR_W] = addr_c[i];
  end

  assign rd_en = en_c;

endmodule

// File: tb/tb_rd_skew_control.sv
// Self-checking bench for rd_skew_control
// Table rows, corner sequences, random vs model
module tb_rd_skew_control;

  localparam int W = 4;
  localparam int A = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [A-1:0]   base_addr;
  logic [A-1:0]   num_rows;
  logic           busy;
  logic           done;
  logic [W-1:0]   rd_en;
  logic [W*A-1:0] rd_addr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  rd_skew_control #(
    .WIDTH_HEIGHT(W),
    .ADDR_W      (A)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .base_addr(base_addr),
    .num_rows (num_rows),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   en;
    logic [W*A-1:0] addr;
    logic           busy;
    logic           done;
  } exp_t;

  typedef struct {
    int b;
    int n;
    int done_d;
    int span;
    int last3;
  } row_t;

  // d = cycles since the start-sampling edge
  function automatic exp_t model(int d, int b, int n);
    exp_t e;
    int   len;
    int   k;
    len    = (n == 0) ? 1 : n + W;
    e.en   = '0;
    e.addr = '0;
    e.busy = (d >= 1) && (d <= len);
    e.done = (d == len);
    for (int i = 0; i < W; i++) begin
      k = d - 1 - i;
      if (k >= 0 && k < n) begin
        e.en[i] = 1'b1;
        e.addr[i*A +: A] = A'(b + k);
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_out(string nm, exp_t e);
    tests++;
    if (rd_en !== e.en || rd_addr !== e.addr ||
        busy !== e.busy || done !== e.done) begin
      fails++;
      $display("FAIL %s cyc=%0d got en=%b a=%h b=%b d=%b want en=%b a=%h b=%b d=%b",
               nm, cyc, rd_en, rd_addr, busy, done,
               e.en, e.addr, e.busy, e.done);
    end
  endtask

  task automatic chk(string nm, int got, int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic kick(int b, int n);
    base_addr = A'(b);
    num_rows  = A'(n);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic run_row(row_t r);
    int d;
    int span;
    int last3;
    int done_d;
    bit ok;
    span   = 0;
    last3  = 0;
    done_d = 0;
    ok     = 1'b0;
    kick(r.b, r.n);
    d = 1;
    for (int j = 0; j < 40; j++) begin
      if (rd_en != '0) span++;
      if (rd_en[W-1]) last3 = int'(rd_addr[(W-1)*A +: A]);
      if (done) done_d = d;
      if (!busy && done_d > 0) begin
        ok = 1'b1;
        break;
      end
      tick();
      d++;
    end
    chk("row_timeout", int'(ok), 1);
    chk("row_done_d", done_d, r.done_d);
    chk("row_span", span, r.span);
    chk("row_last3", last3, r.last3);
  endtask

  task automatic run_model(string nm, int b, int n);
    kick(b, n);
    for (int d = 1; d <= n + W + 1; d++) begin
      check_out(nm, model(d, b, n));
      tick();
    end
  endtask

  row_t rows [5];
  logic [W-1:0] shp [9];

  initial begin
    int   t0;
    int   mb;
    int   mn;
    int   seen_done;
    exp_t e;

    rows[0] = '{b: 'h10, n: 3, done_d: 7, span: 6, last3: 'h12};
    rows[1] = '{b: 'h00, n: 1, done_d: 5, span: 4, last3: 'h00};
    rows[2] = '{b: 'h00, n: 0, done_d: 1, span: 0, last3: 'h00};
    rows[3] = '{b: 'hFE, n: 4, done_d: 8, span: 7, last3: 'h01};
    rows[4] = '{b: 'hFF, n: 2, done_d: 6, span: 5, last3: 'h00};

    shp[0] = 4'b0001; shp[1] = 4'b0011;
    shp[2] = 4'b0111; shp[3] = 4'b1111;
    shp[4] = 4'b1111; shp[5] = 4'b1110;
    shp[6] = 4'b1100; shp[7] = 4'b1000;
    shp[8] = 4'b0000;

    reset     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    num_rows  = '0;
    #12;
    check_out("reset", model(-1, 0, 0));
    reset = 1'b1;
    tick();
    check_out("idle", model(-1, 0, 0));

    foreach (rows[r]) run_row(rows[r]);

    kick('h20, 5);
    for (int d = 1; d <= 9; d++) begin
      chk("shape", int'(rd_en), int'(shp[d-1]));
      tick();
    end

    run_model("diag_n1", 'h00, 1);
    run_model("wrap", 'hFE, 4);

    kick('h10, 3);
    for (int d = 1; d <= 15; d++) begin
      if (d <= 8) e = model(d, 'h10, 3);
      else e = model(d - 8, 'h40, 2);
      check_out("ignore", e);
      start = 1'b0;
      if (d == 2) begin
        base_addr = 8'h80;
        num_rows  = 8'd9;
        start     = 1'b1;
      end
      if (d == 8) begin
        base_addr = 8'h40;
        num_rows  = 8'd2;
        start     = 1'b1;
      end
      tick();
    end
    start = 1'b0;

    kick('h30, 5);
    tick();
    tick();
    check_out("pre_rst", model(3, 'h30, 5));
    #2 reset = 1'b0;
    #1 check_out("async_rst", model(-1, 0, 0));
    seen_done = 0;
    for (int j = 0; j < 6; j++) begin
      tick();
      if (done) seen_done++;
    end
    #3 reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      if (done) seen_done++;
    end
    chk("no_done_rst", seen_done, 0);
    check_out("post_rst", model(-1, 0, 0));
    run_model("fresh", 'h55, 5);

    t0 = -1000;
    mb = 0;
    mn = 0;
    for (int j = 0; j < 3000; j++) begin
      e = model(cyc - t0, mb, mn);
      check_out("rand", e);
      start     = ($urandom_range(0, 5) == 0);
      base_addr = A'($urandom_range(0, 255));
      num_rows  = A'($urandom_range(0, 9));
      if (start && !e.busy) begin
        t0 = cyc;
        mb = int'(base_addr);
        mn = int'(num_rows);
      end
      tick();
    end
    start = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rd_skew_control.md
# rd_skew_control

Read-side sequencer for the systolic array's on-chip memory. On a `start` pulse it generates the staggered per-lane read enables and packed per-lane read addresses that stream rows out of the memory array into the systolic array edge. Lane *i* trails lane *i-1* by exactly one cycle, forming the diagonal wavefront the array requires. It is the read-side counterpart of the write-enable/address generator that fills the same memory, and reports completion with a one-cycle `done` pulse.

## Interface
- `WIDTH_HEIGHT`, 4, number of lanes (array rows/columns)
- `ADDR_W`, 8, per-lane address width in bits
- `clk` input 1 — system clock, all state on rising edge
- `reset` input 1 — asynchronous, active-low; one clock; reset is asynchronous and active-low
- `start` input 1 — request a read burst; sampled only in IDLE
- `base_addr` input ADDR_W — first address read by every lane
- `num_rows` input ADDR_W — reads per lane (N); 0 legal
- `busy` output 1 — high while a burst is in progress (state ≠ IDLE)
- `done` output 1 — single-cycle pulse at burst end
- `rd_en` output WIDTH_HEIGHT — bit *i* = read enable for lane *i*
- `rd_addr` output WIDTH_HEIGHT*ADDR_W — lane *i* address in bits [i*ADDR_W +: ADDR_W]

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `start`=1 latches `base_addr` and `num_rows`. If N≠0, go to RUN. If N=0, go to DONE with no enables.
- RUN: lane 0 asserts `rd_en[0]` for N consecutive cycles with addresses base, base+1, …, base+N-1. Lane *i* reproduces lane 0's enable and address exactly *i* cycles later.
- Exit RUN to DONE after the cycle in which the last lane's final read is driven.
- DONE: `done`=1 for one cycle, then return to IDLE.
- Address arithmetic is modulo 2^ADDR_W; 0xFF+1 wraps to 0x00.
- When `rd_en[i]`=0, lane *i* address field is 0.
- `start` is ignored while `busy`=1. No queuing; the latched parameters are not disturbed.
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0; FSM returns to IDLE.
- Reset asserted mid-burst clears everything immediately (asynchronously). The burst is abandoned with no `done` pulse.

## Timing
- Let edge T be the edge that samples `start`=1 in IDLE, with W=WIDTH_HEIGHT.
- `busy` is high from cycle T+1 through the `done` cycle inclusive.
- `rd_en[i]` is high in cycles T+1+i … T+N+i. Lane *i* address in cycle T+1+i+k is base+k, for k = 0…N-1.
- `rd_en` shape for W=4, N≥4: 0001, 0011, 0111, 1111 (held), then 1110, 1100, 1000, 0000.
- `done` is asserted in cycle T+N+W. For N=0, `done` is asserted in cycle T+1.
- `busy` is low in cycle T+N+W+1, and a new `start` can be sampled on that edge. Minimum burst-to-burst spacing is N+W+1 cycles.
- Total enable-active span is N+W-1 cycles.

## Structure
- Shared package holds:
  - default `WIDTH_HEIGHT` and `ADDR_W` constants
  - the FSM state encoding (IDLE, RUN, DONE)
  - the lane-slice helper width constant
- Lane 0 is produced by a down-counter of remaining reads plus an address register.
- Lanes 1…W-1 are a delay chain, each built from one instance of sub-module `rd_skew_stage`.
  - `rd_skew_stage` registers {enable, address} from the previous lane.
  - It has the same async active-low `reset` and outputs 0 when disabled.
- The FSM counts a drain counter of W cycles after lane 0 finishes, then enters DONE.

## Test plan
- W=4, base=0x10, N=3, start at T → `rd_en[0]` at T+1..T+3 with addr 0x10, 0x11, 0x12; `rd_en[3]` at T+4..T+6 with the same addresses; `done` at T+7; `busy` low at T+8.
- N=1, base=0x00 → single diagonal 0001, 0010, 0100, 1000 at T+1..T+4, all addresses 0; `done` at T+5.
- N=0 → `rd_en` stays 0; `busy`=1 and `done`=1 at T+1; IDLE at T+2.
- base=0xFE, N=4 → each lane reads 0xFE, 0xFF, 0x00, 0x01 in order.
- `start` pulsed at T+2 with different base/N during the burst → ignored; the burst completes exactly as the first request. A `start` at T+N+W+1 is accepted.
- `reset` driven low at T+3 of an N=5 burst → all outputs 0 without waiting for a clock edge; no `done` pulse; a fresh `start` after release runs a normal burst.
